// File: rtl/seq_divider_if.sv
// Operand/result bundle for the sequential divider; master drives operands and load.
interface seq_divider_if #(
  parameter int unsigned N = 4
);
  logic             load;
  logic [2*N-1:0]   dividend;
  logic [N-1:0]     divisor;
  logic [2*N-1:0]   quotient;
  logic [N-1:0]     remainder;
  logic             op_ready;
  logic             div_by_zero;
  logic             busy;

  modport master (
    output load, dividend, divisor,
    input  quotient, remainder, op_ready, div_by_zero, busy
  );

  modport slave (
    input  load, dividend, divisor,
    output quotient, remainder, op_ready, div_by_zero, busy
  );
endinterface

// File: rtl/seq_divider.sv
// Restoring divider: 2N-bit dividend by N-bit divisor, one quotient bit per clock.
module seq_divider #(
  parameter int unsigned N = 4
) (
  input logic          clk,
  input logic          rst,
  seq_divider_if.slave bus
);
  localparam int unsigned DW = 2 * N;
  localparam int unsigned CW = (DW > 1) ? $clog2(DW) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state_q, state_d;
  logic [DW-1:0]   dvd_q;
  logic [N-1:0]    dvs_q;
  logic [N-1:0]    pr_q;
  logic [CW-1:0]   cnt_q;

  logic            start, zero_ld, step, last;
  logic [N:0]      pr_shift;
  logic            q_bit;
  logic [N-1:0]    pr_sub;
  logic [N-1:0]    pr_d;
  logic [DW-1:0]   dvd_d;

  // Between steps the partial remainder is below the divisor, so N bits hold it;
  // the shifted-in value needs N+1 bits only for the comparison.
  assign pr_shift = {pr_q, dvd_q[DW-1]};
  assign q_bit    = (pr_shift >= {1'b0, dvs_q});
  assign pr_sub   = pr_shift[N-1:0] - dvs_q;
  assign pr_d     = q_bit ? pr_sub : pr_shift[N-1:0];
  // Quotient bits enter at the LSB as dividend bits leave the MSB.
  assign dvd_d    = {dvd_q[DW-2:0], q_bit};

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    zero_ld = 1'b0;
    step    = 1'b0;
    last    = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (bus.load) begin
          if (bus.divisor == '0) begin
            zero_ld = 1'b1;
            state_d = DONE;
          end else begin
            start   = 1'b1;
            state_d = RUN;
          end
        end
      end
      RUN: begin
        step = 1'b1;
        if (cnt_q == CW'(DW - 1)) begin
          last    = 1'b1;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Working registers and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      dvd_q           <= '0;
      dvs_q           <= '0;
      pr_q            <= '0;
      cnt_q           <= '0;
      bus.quotient    <= '0;
      bus.remainder   <= '0;
      bus.op_ready    <= 1'b0;
      bus.div_by_zero <= 1'b0;
      bus.busy        <= 1'b0;
    end else begin
      if (zero_ld) begin
        bus.quotient    <= '1;
        bus.remainder   <= '0;
        bus.op_ready    <= 1'b1;
        bus.div_by_zero <= 1'b1;
        bus.busy        <= 1'b0;
      end
      if (start) begin
        dvd_q           <= bus.dividend;
        dvs_q           <= bus.divisor;
        pr_q            <= '0;
        cnt_q           <= '0;
        bus.op_ready    <= 1'b0;
        bus.div_by_zero <= 1'b0;
        bus.busy        <= 1'b1;
      end
      if (step) begin
        dvd_q <= dvd_d;
        pr_q  <= pr_d;
        cnt_q <= cnt_q + CW'(1);
      end
      if (last) begin
        bus.quotient    <= dvd_d;
        bus.remainder   <= pr_d;
        bus.op_ready    <= 1'b1;
        bus.div_by_zero <= 1'b0;
        bus.busy        <= 1'b0;
      end
    end
  end
endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
Sequential restoring divider. It is the inverse companion of the team's shift-add multiplier: it takes a 2N-bit dividend (a product-width value) and an N-bit divisor. It returns a 2N-bit quotient and an N-bit remainder after 2N clock cycles, one quotient bit per cycle. It uses the same load / op_ready handshake as the multiplier, so the two blocks can be exercised back-to-back on one bench.

Parameters:
N, 4, divisor and remainder width; dividend and quotient width is 2N

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous, active-high reset
load  input  1  start request, sampled on rising edge of clk
dividend  input  2N  dividend operand, captured on accepted load
divisor  input  N  divisor operand, captured on accepted load
quotient  output  2N  quotient, valid while op_ready=1
remainder  output  N  remainder, valid while op_ready=1
op_ready  output  1  result valid; held until next accepted load or rst
div_by_zero  output  1  set with op_ready when the captured divisor was 0
busy  output  1  high while iterating

Behaviour:
- Reset (rst=1 at an edge, priority over everything): state=IDLE.
  - quotient=0, remainder=0, op_ready=0, div_by_zero=0, busy=0.
  - Internal partial remainder and counter cleared.
- Reset mid-operation aborts the division; no result is produced.
- States: IDLE, RUN, DONE.
- IDLE, load=1, divisor!=0:
  - Capture operands, partial remainder (N+1 bits)=0, count=0.
  - Go to RUN; busy=1, op_ready=0.
- IDLE or DONE, load=1, divisor==0:
  - Go to DONE at that edge; quotient={2N{1}}, remainder=0, div_by_zero=1, op_ready=1, busy=0.
- RUN, one step per edge, MSB of dividend first:
  - pr = {pr[N-1:0], next dividend bit}.
  - If pr >= {1'b0,divisor}: pr = pr - divisor and quotient bit = 1; else quotient bit = 0.
  - Quotient bits shift in from the LSB.
- RUN, after the 2N-th step (count reaches 2N-1):
  - Same edge: go to DONE, op_ready=1, busy=0, div_by_zero=0.
  - remainder=pr[N-1:0], quotient final.
- Latency: op_ready rises 2N rising edges after the edge that accepted load (8 cycles for N=4).
- RUN ignores load; operands are not re-captured and the operation is not restarted.
- DONE:
  - Outputs hold stable while load=0.
  - load=1 with divisor!=0 is accepted as in IDLE: op_ready and div_by_zero clear at that edge, busy=1.
- Operand inputs may change freely after the accepting edge; only the captured copies are used.
- Invariant on every completed non-zero-divisor operation: dividend == quotient*divisor + remainder, and remainder < divisor.
- Arithmetic is unsigned only; no overflow is possible (quotient width equals dividend width).

Test Plan:
- rst=1 one cycle, then hold load=0 -> quotient=0, remainder=0, op_ready=0, busy=0, div_by_zero=0.
- dividend=36, divisor=3, load pulse -> busy for 8 cycles, then op_ready=1, quotient=12, remainder=0.
- dividend=200, divisor=7 -> quotient=28, remainder=4.
- dividend=225, divisor=15 -> quotient=15, remainder=0; then load again with dividend=110, divisor=11 from DONE -> op_ready drops next edge, 8 cycles later quotient=10, remainder=0.
- divisor=0, dividend=50, load -> next edge op_ready=1, div_by_zero=1, quotient=255, remainder=0, busy=0.
- Load dividend=255, divisor=1, then after 3 cycles apply load with new operands and, in a separate run, rst=1:
  - Extra load: ignored; result is quotient=255, remainder=0 at cycle 8.
  - rst run: all outputs return to 0 at the next edge and op_ready never asserts.
